// File: rtl/ibwt_top.sv
// rtl/ibwt_top.sv - inverse Burrows-Wheeler decoder for one 32-byte block
// Builds the LF map one row per cycle, then walks it backwards from the sentinel row.
module ibwt_top #(
  parameter int         STRING_LEN = 32,
  parameter logic [7:0] SENTINEL   = 8'h24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*STRING_LEN-1:0] input_string_char,
  output logic [8*STRING_LEN-1:0] output_string_char,
  output logic                    valid_out,
  output logic                    error,
  output logic                    busy
);
  localparam int N  = STRING_LEN;
  localparam int IW = $clog2(STRING_LEN);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
  localparam logic [IW-1:0] LAST_WALK = IW'(N - 2);
  localparam logic [IW:0]   CNT_ONE   = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SCAN, S_WALK, S_DONE, S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        l_q  [N];
  logic [7:0]        l_d  [N];
  logic [IW-1:0]     lf_q [N];
  logic [IW-1:0]     lf_d [N];
  logic [7:0]        t_q  [N];
  logic [7:0]        t_d  [N];
  logic [IW-1:0]     idx_q, idx_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IW-1:0]     r0_q, r0_d;
  logic [IW-1:0]     row_q, row_d;
  logic [8*N-1:0]    out_q, out_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;

  logic [7:0]        cur_sym;
  logic [IW:0]       lt_cnt, rk_cnt;
  logic [IW-1:0]     lf_sum;
  logic [IW-1:0]     next_row;
  logic [IW-1:0]     walk_pos;
  logic [8*N-1:0]    t_packed;

  // LF(i) = #symbols smaller than L[i] + #earlier occurrences of L[i]
  always_comb begin
    cur_sym = l_q[idx_q];
    lt_cnt  = '0;
    rk_cnt  = '0;
    for (int j = 0; j < N; j++) begin
      if (l_q[j] < cur_sym) lt_cnt = lt_cnt + CNT_ONE;
      if ((IW'(j) < idx_q) && (l_q[j] == cur_sym)) rk_cnt = rk_cnt + CNT_ONE;
    end
    lf_sum = IW'(lt_cnt + rk_cnt);
  end

  always_comb begin
    next_row = lf_q[row_q];
    walk_pos = LAST_WALK - idx_q;
    t_packed = '0;
    for (int k = 0; k < N; k++) t_packed[8*k +: 8] = t_q[k];
  end

  always_comb begin
    state_d = state_q;
    l_d     = l_q;
    lf_d    = lf_q;
    t_d     = t_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    r0_d    = r0_q;
    row_d   = row_q;
    out_d   = out_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        out_d   = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        for (int k = 0; k < N; k++) l_d[k] = input_string_char[8*k +: 8];
        idx_d   = '0;
        cnt_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        lf_d[idx_q] = lf_sum;
        if (cur_sym == SENTINEL) begin
          r0_d = idx_q;
          if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (cnt_d != 2'd1) begin
            state_d = S_DONE;
          end else begin
            row_d      = r0_d;
            t_d[N-1]   = SENTINEL;
            state_d    = S_WALK;
          end
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WALK: begin
        row_d         = next_row;
        t_d[walk_pos] = l_q[next_row];
        if (idx_q == LAST_WALK) state_d = S_DONE;
        else                    idx_d   = idx_q + IW'(1);
      end
      S_DONE: begin
        valid_d = 1'b1;
        if (cnt_q != 2'd1) begin
          err_d = 1'b1;
          out_d = '0;
        end else begin
          err_d = 1'b0;
          out_d = t_packed;
        end
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // outputs clear on the way out so IDLE always presents zeros
        if (!start) begin
          out_d   = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      r0_q    <= '0;
      row_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      r0_q    <= r0_d;
      row_q   <= row_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // data arrays are always rewritten before use, so they carry no reset
  always_ff @(posedge clk) begin
    l_q  <= l_d;
    lf_q <= lf_d;
    t_q  <= t_d;
  end

  assign output_string_char = out_q;
  assign valid_out          = valid_q;
  assign error              = err_q;
  assign busy               = (state_q == S_LOAD) || (state_q == S_SCAN) || (state_q == S_WALK);

endmodule
